if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage.sv | 132 +++++++++++++
 tb/tb_if_fetch_stage.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction ROM and fills the
// IF/ID pipeline register, with stall, flush, branch redirect and misalignment halt.
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              branchTaken,
    input  logic [ADDR_W-1:0] branchTarget,
    output logic              romChipEnable,
    output logic [ADDR_W-1:0] romAddr,
    input  logic [INST_W-1:0] romInst,
    output logic [ADDR_W-1:0] idPc,
    output logic [INST_W-1:0] idInst,
    output logic              idValid,
    output logic              fetchFault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t            state;
    state_t            stateNext;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pcNext;
    logic [ADDR_W-1:0] idPcNext;
    logic [INST_W-1:0] idInstNext;
    logic              idValidNext;
    logic              fetchFaultNext;
    logic              pendValid;
    logic              pendValidNext;
    logic [ADDR_W-1:0] pendTarget;
    logic [ADDR_W-1:0] pendTargetNext;
    logic [ADDR_W-1:0] redirect;
    logic              hasRedirect;

    assign romAddr       = pc;
    assign romChipEnable = (state == FETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            idPc       <= '0;
            idInst     <= '0;
            idValid    <= 1'b0;
            fetchFault <= 1'b0;
            pendValid  <= 1'b0;
            pendTarget <= '0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            idPc       <= idPcNext;
            idInst     <= idInstNext;
            idValid    <= idValidNext;
            fetchFault <= fetchFaultNext;
            pendValid  <= pendValidNext;
            pendTarget <= pendTargetNext;
        end
    end

    always_comb begin
        stateNext      = state;
        pcNext         = pc;
        idPcNext       = idPc;
        idInstNext     = idInst;
        idValidNext    = idValid;
        fetchFaultNext = fetchFault;
        pendValidNext  = pendValid;
        pendTargetNext = pendTarget;
        redirect       = '0;
        hasRedirect    = 1'b0;

        // A live branch beats a parked one; a parked one only fires once the stall drops.
        if (branchTaken) begin
            redirect    = branchTarget;
            hasRedirect = 1'b1;
        end else if (pendValid && !stall) begin
            redirect    = pendTarget;
            hasRedirect = 1'b1;
        end

        case (state)
            IDLE: begin
                stateNext = FETCH;
            end
            FETCH: begin
                if (hasRedirect && (redirect[1:0] != 2'b00)) begin
                    fetchFaultNext = 1'b1;
                    stateNext      = HALT;
                    idValidNext    = 1'b0;
                    pendValidNext  = 1'b0;
                end else if (stall) begin
                    if (branchTaken) begin
                        pendValidNext  = 1'b1;
                        pendTargetNext = branchTarget;
                    end
                end else if (hasRedirect) begin
                    pcNext        = redirect;
                    pendValidNext = 1'b0;
                    idValidNext   = 1'b0;
                end else begin
                    idInstNext  = romInst;
                    idPcNext    = pc;
                    idValidNext = 1'b1;
                    pcNext      = pc + ADDR_W'(4);
                end
            end
            HALT: begin
                stateNext = HALT;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase

        // Flush squashes IF/ID in every state and regardless of stall.
        if (flush) begin
            idValidNext = 1'b0;
            idInstNext  = '0;
            idPcNext    = '0;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage: a ROM model feeds the DUT and a
// scoreboard queue holds the {pc, inst} captures the IF/ID register must show.
module tb_if_fetch_stage;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } sb_t;

    logic              clk;
    logic              rst_n;
    logic              stall;
    logic              flush;
    logic              branchTaken;
    logic [ADDR_W-1:0] branchTarget;
    logic              romChipEnable;
    logic [ADDR_W-1:0] romAddr;
    logic [INST_W-1:0] romInst;
    logic [ADDR_W-1:0] idPc;
    logic [INST_W-1:0] idInst;
    logic              idValid;
    logic              fetchFault;

    sb_t sbQ[$];
    sb_t exp;
    int  nCompared;
    int  nMismatched;

    if_fetch_stage #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .flush(flush),
        .branchTaken(branchTaken),
        .branchTarget(branchTarget),
        .romChipEnable(romChipEnable),
        .romAddr(romAddr),
        .romInst(romInst),
        .idPc(idPc),
        .idInst(idInst),
        .idValid(idValid),
        .fetchFault(fetchFault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [INST_W-1:0] romWord(input logic [ADDR_W-1:0] a);
        if (a == 32'h0) return 32'h3401_0011;
        if (a == 32'h4) return 32'h3402_0022;
        return 32'hC0DE_0000 ^ a;
    endfunction

    always_comb romInst = romWord(romAddr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [ADDR_W-1:0] a);
        sb_t e;
        e.pc   = a;
        e.inst = romWord(a);
        sbQ.push_back(e);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        branchTaken = 1'b0; branchTarget = '0;
        tick(); tick();
        nCompared++;
        if ({romChipEnable, romAddr, idValid, idPc, idInst, fetchFault} !== {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL reset_state: ce=%b addr=%h v=%b pc=%h inst=%h fault=%b required all zero",
                     romChipEnable, romAddr, idValid, idPc, idInst, fetchFault);
        end
    endtask

    task automatic test_startup();
        rst_n = 1'b1;
        #1;
        nCompared++;
        if ({romChipEnable, romAddr} !== {1'b0, 32'h0}) begin
            nMismatched++;
            $display("[TB] FAIL idle_cycle: ce=%b addr=%h required ce=0 addr=0", romChipEnable, romAddr);
        end
        tick();
        nCompared++;
        if (romChipEnable !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL fetch_enable: ce=%b required 1", romChipEnable);
        end
        for (int i = 0; i < 2; i++) begin
            pushExp(ADDR_W'(i * 4));
            tick();
            exp = sbQ.pop_front();
            nCompared++;
            if ({idValid, idPc, idInst, romAddr} !== {1'b1, exp.pc, exp.inst, exp.pc + 32'd4}) begin
                nMismatched++;
                $display("[TB] FAIL startup_capture%0d: v=%b pc=%h inst=%h addr=%h required v=1 pc=%h inst=%h addr=%h",
                         i, idValid, idPc, idInst, romAddr, exp.pc, exp.inst, exp.pc + 32'd4);
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            nCompared++;
            if ({romAddr, idPc, idInst} !== {32'h8, 32'h4, 32'h3402_0022}) begin
                nMismatched++;
                $display("[TB] FAIL stall_hold%0d: addr=%h pc=%h inst=%h required addr=8 pc=4 inst=34020022",
                         i, romAddr, idPc, idInst);
            end
        end
        stall = 1'b0;
        pushExp(32'h8);
        tick();
        exp = sbQ.pop_front();
        nCompared++;
        if ({idValid, idPc, idInst, romAddr} !== {1'b1, exp.pc, exp.inst, 32'hC}) begin
            nMismatched++;
            $display("[TB] FAIL stall_release: v=%b pc=%h inst=%h addr=%h required v=1 pc=%h inst=%h addr=c",
                     idValid, idPc, idInst, romAddr, exp.pc, exp.inst);
        end
    endtask

    task automatic test_branch();
        branchTaken = 1'b1; branchTarget = 32'h20;
        tick();
        branchTaken = 1'b0;
        nCompared++;
        if ({romAddr, idValid} !== {32'h20, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL branch_redirect: addr=%h v=%b required addr=20 v=0", romAddr, idValid);
        end
        pushExp(32'h20);
        tick();
        exp = sbQ.pop_front();
        nCompared++;
        if ({idValid, idPc, idInst, romAddr} !== {1'b1, exp.pc, exp.inst, 32'h24}) begin
            nMismatched++;
            $display("[TB] FAIL branch_target_capture: v=%b pc=%h inst=%h addr=%h required v=1 pc=%h inst=%h addr=24",
                     idValid, idPc, idInst, romAddr, exp.pc, exp.inst);
        end
    endtask

    task automatic test_pending_redirect();
        stall = 1'b1;
        branchTaken = 1'b1; branchTarget = 32'h10;
        tick();
        branchTarget = 32'h30;
        tick();
        branchTaken = 1'b0; branchTarget = '0;
        tick();
        nCompared++;
        if ({romAddr, idPc} !== {32'h24, 32'h20}) begin
            nMismatched++;
            $display("[TB] FAIL pending_hold: addr=%h pc=%h required addr=24 pc=20", romAddr, idPc);
        end
        stall = 1'b0;
        tick();
        nCompared++;
        if ({romAddr, idValid} !== {32'h30, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL pending_latest_wins: addr=%h v=%b required addr=30 v=0", romAddr, idValid);
        end
        pushExp(32'h30);
        tick();
        exp = sbQ.pop_front();
        nCompared++;
        if ({idValid, idPc, idInst} !== {1'b1, exp.pc, exp.inst}) begin
            nMismatched++;
            $display("[TB] FAIL pending_capture: v=%b pc=%h inst=%h required v=1 pc=%h inst=%h",
                     idValid, idPc, idInst, exp.pc, exp.inst);
        end
    endtask

    task automatic test_flush_stall();
        stall = 1'b1; flush = 1'b1;
        tick();
        stall = 1'b0; flush = 1'b0;
        nCompared++;
        if ({idValid, idInst, idPc, romAddr} !== {1'b0, 32'h0, 32'h0, 32'h34}) begin
            nMismatched++;
            $display("[TB] FAIL flush_with_stall: v=%b inst=%h pc=%h addr=%h required v=0 inst=0 pc=0 addr=34",
                     idValid, idInst, idPc, romAddr);
        end
        pushExp(32'h34);
        tick();
        exp = sbQ.pop_front();
        nCompared++;
        if ({idValid, idPc, idInst} !== {1'b1, exp.pc, exp.inst}) begin
            nMismatched++;
            $display("[TB] FAIL post_flush_capture: v=%b pc=%h inst=%h required v=1 pc=%h inst=%h",
                     idValid, idPc, idInst, exp.pc, exp.inst);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        nCompared++;
        if ({idValid, idInst, romAddr} !== {1'b0, 32'h0, 32'h3C}) begin
            nMismatched++;
            $display("[TB] FAIL flush_pc_advances: v=%b inst=%h addr=%h required v=0 inst=0 addr=3c",
                     idValid, idInst, romAddr);
        end
    endtask

    task automatic test_fault();
        branchTaken = 1'b1; branchTarget = 32'h6;
        tick();
        branchTaken = 1'b0; branchTarget = '0;
        for (int i = 0; i < 3; i++) begin
            nCompared++;
            if ({fetchFault, romChipEnable, idValid, romAddr} !== {1'b1, 1'b0, 1'b0, 32'h3C}) begin
                nMismatched++;
                $display("[TB] FAIL fault_halt%0d: fault=%b ce=%b v=%b addr=%h required fault=1 ce=0 v=0 addr=3c",
                         i, fetchFault, romChipEnable, idValid, romAddr);
            end
            tick();
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        nCompared++;
        if ({fetchFault, romChipEnable, romAddr} !== {1'b0, 1'b0, 32'h0}) begin
            nMismatched++;
            $display("[TB] FAIL fault_reset_clear: fault=%b ce=%b addr=%h required fault=0 ce=0 addr=0",
                     fetchFault, romChipEnable, romAddr);
        end
        tick();
        pushExp(32'h0);
        tick();
        exp = sbQ.pop_front();
        nCompared++;
        if ({idValid, idPc, idInst, romAddr} !== {1'b1, exp.pc, exp.inst, 32'h4}) begin
            nMismatched++;
            $display("[TB] FAIL restart_capture: v=%b pc=%h inst=%h addr=%h required v=1 pc=%h inst=%h addr=4",
                     idValid, idPc, idInst, romAddr, exp.pc, exp.inst);
        end
    endtask

    task automatic test_wrap();
        branchTaken = 1'b1; branchTarget = 32'hFFFF_FFFC;
        tick();
        branchTaken = 1'b0; branchTarget = '0;
        nCompared++;
        if ({romAddr, idValid} !== {32'hFFFF_FFFC, 1'b0}) begin
            nMismatched++;
            $display("[TB] FAIL wrap_redirect: addr=%h v=%b required addr=fffffffc v=0", romAddr, idValid);
        end
        pushExp(32'hFFFF_FFFC);
        tick();
        exp = sbQ.pop_front();
        nCompared++;
        if ({idValid, idPc, idInst, romAddr} !== {1'b1, exp.pc, exp.inst, 32'h0}) begin
            nMismatched++;
            $display("[TB] FAIL wrap_around: v=%b pc=%h inst=%h addr=%h required v=1 pc=%h inst=%h addr=0",
                     idValid, idPc, idInst, romAddr, exp.pc, exp.inst);
        end
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        $display("[TB] starting if_fetch_stage bench");
        test_reset();
        test_startup();
        test_stall();
        test_branch();
        test_pending_redirect();
        test_flush_stall();
        test_fault();
        test_wrap();
        nCompared++;
        if (sbQ.size() !== 0) begin
            nMismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left required 0", sbQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
